// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider.
//   state_e     : controller states IDLE / ITER / FINISH
//   DIV_N       : default operand width
//   DIV_MAX_W   : widest operand the helper functions support
//   div_cnt_w   : iteration counter width for a given operand width
//   cond_negate : two's-complement magnitude / negate helper
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int DIV_N     = 32;
  localparam int DIV_MAX_W = 64;

  // Counter must index 0..n-1; keep at least one bit for degenerate widths.
  function automatic int div_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Negates v when neg is set. Callers zero-extend an N-bit value into the
  // wide argument and cast the result back to N bits, so the arithmetic is
  // effectively modulo 2^N. Taking the magnitude of a value is
  // cond_negate(v, sign_of_v); the most negative value maps to 2^(N-1).
  function automatic logic [DIV_MAX_W-1:0] cond_negate(input logic [DIV_MAX_W-1:0] v,
                                                       input logic                 neg);
    if (neg) begin
      return ~v + 64'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/div_addsub.sv
// Combinational W-bit adder/subtractor for the divider datapath.
//   i_a   : first operand
//   i_b   : second operand
//   i_sub : 1 -> o_y = i_a - i_b, 0 -> o_y = i_a + i_b
//   o_y   : result, modulo 2^W
module div_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_y
);

  logic [W-1:0] w_b_eff;

  // Subtraction is addition of the inverted operand with a carry-in of one.
  assign w_b_eff = i_b ^ {W{i_sub}};
  assign o_y     = i_a + w_b_eff + {{(W-1){1'b0}}, i_sub};

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider, radix-2 non-restoring, truncating (C semantics).
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : request, honoured only while idle
//   dividend, divisor     : signed operands, sampled with start
//   quotient, remainder   : signed results, registered, held until next done
//   busy                  : operation in flight
//   done                  : one-cycle pulse, results valid
//   div_by_zero, overflow : status flags, updated only with done
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CNT_W = div_cnt_w(N);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N:0]       r_p, w_p_nxt;          // signed partial remainder
  logic [N-1:0]     r_q, w_q_nxt;          // dividend magnitude shifting into quotient
  logic [N-1:0]     r_d, w_d_nxt;          // divisor magnitude
  logic             r_dvd_neg, w_dvd_neg_nxt;
  logic             r_q_neg, w_q_neg_nxt;
  logic             r_dbz_pend, w_dbz_pend_nxt;
  logic             r_ovf_pend, w_ovf_pend_nxt;
  logic [N-1:0]     r_quot, w_quot_nxt;
  logic [N-1:0]     r_rem, w_rem_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_dbz, w_dbz_nxt;
  logic             r_ovf, w_ovf_nxt;

  logic [N-1:0]     w_dvd_mag, w_dsr_mag, w_rem_mag;
  logic             w_fin;
  logic [N:0]       w_as_a, w_as_y;
  logic             w_as_sub;

  assign w_dvd_mag = N'(cond_negate(DIV_MAX_W'(dividend), dividend[N-1]));
  assign w_dsr_mag = N'(cond_negate(DIV_MAX_W'(divisor), divisor[N-1]));

  // One adder serves both the iteration step and the final remainder fix-up:
  // in FINISH it adds D back to P, otherwise it works on the shifted P.
  assign w_fin    = (r_state == FINISH);
  assign w_as_a   = w_fin ? r_p : {r_p[N-1:0], r_q[N-1]};
  assign w_as_sub = w_fin ? 1'b0 : ~r_p[N];

  div_addsub #(.W(N + 1)) u_addsub (
    .i_a   (w_as_a),
    .i_b   ({1'b0, r_d}),
    .i_sub (w_as_sub),
    .o_y   (w_as_y)
  );

  assign w_rem_mag = r_p[N] ? w_as_y[N-1:0] : r_p[N-1:0];

  // Controller next-state and datapath next values.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_p_nxt        = r_p;
    w_q_nxt        = r_q;
    w_d_nxt        = r_d;
    w_dvd_neg_nxt  = r_dvd_neg;
    w_q_neg_nxt    = r_q_neg;
    w_dbz_pend_nxt = r_dbz_pend;
    w_ovf_pend_nxt = r_ovf_pend;
    w_quot_nxt     = r_quot;
    w_rem_nxt      = r_rem;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_dbz_nxt      = r_dbz;
    w_ovf_nxt      = r_ovf;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_p_nxt        = {(N+1){1'b0}};
          w_q_nxt        = w_dvd_mag;
          w_d_nxt        = w_dsr_mag;
          w_dvd_neg_nxt  = dividend[N-1];
          w_q_neg_nxt    = dividend[N-1] ^ divisor[N-1];
          w_dbz_pend_nxt = (divisor == {N{1'b0}});
          w_ovf_pend_nxt = (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == {N{1'b1}});
          w_cnt_nxt      = {CNT_W{1'b0}};
          w_busy_nxt     = 1'b1;
          w_state_nxt    = (divisor == {N{1'b0}}) ? FINISH : ITER;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ITER: begin
        // New quotient bit is 1 exactly when the updated P is non-negative.
        w_p_nxt = w_as_y;
        w_q_nxt = {r_q[N-2:0], ~w_as_y[N]};
        if (r_cnt == CNT_W'(N - 1)) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = FINISH;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = ITER;
        end
      end
      FINISH: begin
        if (r_dbz_pend) begin
          // No iterations ran, so r_q still holds the dividend magnitude.
          w_quot_nxt = {N{1'b1}};
          w_rem_nxt  = N'(cond_negate(DIV_MAX_W'(r_q), r_dvd_neg));
        end else begin
          w_quot_nxt = N'(cond_negate(DIV_MAX_W'(r_q), r_q_neg));
          w_rem_nxt  = N'(cond_negate(DIV_MAX_W'(w_rem_mag), r_dvd_neg));
        end
        w_dbz_nxt   = r_dbz_pend;
        w_ovf_nxt   = r_ovf_pend;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_p        <= {(N+1){1'b0}};
      r_q        <= {N{1'b0}};
      r_d        <= {N{1'b0}};
      r_dvd_neg  <= 1'b0;
      r_q_neg    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_quot     <= {N{1'b0}};
      r_rem      <= {N{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_p        <= w_p_nxt;
      r_q        <= w_q_nxt;
      r_d        <= w_d_nxt;
      r_dvd_neg  <= w_dvd_neg_nxt;
      r_q_neg    <= w_q_neg_nxt;
      r_dbz_pend <= w_dbz_pend_nxt;
      r_ovf_pend <= w_ovf_pend_nxt;
      r_quot     <= w_quot_nxt;
      r_rem      <= w_rem_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_dbz      <= w_dbz_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic         busy, done, div_by_zero, overflow;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit signed division truncates toward zero and the
  // remainder follows the dividend's sign; results wrap to N bits.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r,
                                output logic dz, output logic ov);
    longint sa, sb, sq, sr;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (sb == 0) begin
      q = '1; r = a; dz = 1'b1; ov = 1'b0;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      q  = N'(sq);
      r  = N'(sr);
      dz = 1'b0;
      ov = (sq > ((64'sd1 <<< (N - 1)) - 64'sd1));
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge; returns at the falling edge after the
  // sampling edge E0.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
  endtask

  // Called at the falling edge after E0. Waits (bounded) for done, optionally
  // pulsing start at sample indices spur_a/spur_b, or holding start high.
  task automatic wait_check(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input int spur_a, input int spur_b, input bit hold);
    logic [N-1:0] eq, er;
    logic edz, eov;
    int j, exp_lat;
    bit got, busy_ok;
    model(a, b, eq, er, edz, eov);
    exp_lat = edz ? 1 : N + 1;
    j = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && j < 4 * N) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        start = hold || (j == spur_a) || (j == spur_b);
        if (!hold) begin
          dividend = $urandom;
          divisor  = $urandom;
        end
        @(negedge clk);
        j++;
      end
    end
    check({tag, "/done_seen"}, 64'(got), 64'd1);
    check({tag, "/latency"}, 64'(j), 64'(exp_lat));
    check({tag, "/busy_before_done"}, 64'(busy_ok), 64'd1);
    check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "/quotient"}, 64'(quotient), 64'(eq));
    check({tag, "/remainder"}, 64'(remainder), 64'(er));
    check({tag, "/div_by_zero"}, 64'(div_by_zero), 64'(edz));
    check({tag, "/overflow"}, 64'(overflow), 64'(eov));
    start = hold;
    if (!hold) begin
      @(negedge clk);
      check({tag, "/done_pulse"}, 64'(done), 64'd0);
      check({tag, "/quotient_held"}, 64'(quotient), 64'(eq));
    end
  endtask

  logic [N-1:0] dir_a [8];
  logic [N-1:0] dir_b [8];

  initial begin
    int seen;
    logic [N-1:0] ra, rb;

    // Reset state, observed after the first clock edge under reset.
    @(negedge clk);
    check("reset/quotient", 64'(quotient), 64'd0);
    check("reset/remainder", 64'(remainder), 64'd0);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/div_by_zero", 64'(div_by_zero), 64'd0);
    check("reset/overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed: signs, divide-by-zero then recovery, overflow and its neighbour.
    dir_a[0] = 32'd100;        dir_b[0] = 32'd7;
    dir_a[1] = 32'hFFFFFF9C;   dir_b[1] = 32'd7;
    dir_a[2] = 32'd100;        dir_b[2] = 32'hFFFFFFF9;
    dir_a[3] = 32'hFFFFFF9C;   dir_b[3] = 32'hFFFFFFF9;
    dir_a[4] = 32'd5;          dir_b[4] = 32'd0;
    dir_a[5] = 32'd6;          dir_b[5] = 32'd3;
    dir_a[6] = 32'h80000000;   dir_b[6] = 32'hFFFFFFFF;
    dir_a[7] = 32'h80000000;   dir_b[7] = 32'd1;
    for (int i = 0; i < 8; i++) begin
      issue(dir_a[i], dir_b[i]);
      wait_check($sformatf("dir%0d", i), dir_a[i], dir_b[i], -1, -1, 1'b0);
    end

    // Starts pulsed while busy must be ignored: exactly one done.
    issue(32'd9, 32'd2);
    wait_check("spurious", 32'd9, 32'd2, 5, 20, 1'b0);
    seen = 0;
    for (int k = 0; k < 2 * N; k++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    check("spurious/extra_done", 64'(seen), 64'd0);

    // Start held through done: second operation accepted on the done cycle.
    issue(32'd45, 32'hFFFFFFFA);
    dividend = 32'hFFFFF000;
    divisor  = 32'd33;
    wait_check("hold/first", 32'd45, 32'hFFFFFFFA, -1, -1, 1'b1);
    @(negedge clk);
    wait_check("hold/second", 32'hFFFFF000, 32'd33, -1, -1, 1'b0);

    // Asynchronous reset in the middle of an iteration aborts at once.
    issue(32'd12345, 32'd17);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort/quotient", 64'(quotient), 64'd0);
    check("abort/remainder", 64'(remainder), 64'd0);
    check("abort/busy", 64'(busy), 64'd0);
    check("abort/done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 2 * N; k++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    check("abort/no_done", 64'(seen), 64'd0);
    issue(32'd1000, 32'd10);
    wait_check("after_abort", 32'd1000, 32'd10, -1, -1, 1'b0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        rb = $urandom;
      end else begin
        rb = 32'($urandom_range(1, 1000));
        if ($urandom_range(0, 1) == 1) rb = 32'd0 - rb;
      end
      if ($urandom_range(0, 15) == 0) rb = 32'd0;
      issue(ra, rb);
      wait_check($sformatf("rand%0d", i), ra, rb, -1, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
